// File: rtl/proc_ctrl_pkg.sv
// Types and defaults shared by the processor control sequencer and its timer.
package proc_ctrl_pkg;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DECODE = 2'd1,
    MEM    = 2'd2,
    FAULT  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    ALU_PASS = 2'd0,
    ALU_ADD  = 2'd1,
    ALU_SUB  = 2'd2
  } alu_op_t;

  localparam int WAIT_MAX_DEFAULT = 15;
  localparam int WAIT_CNT_W       = 8;

endpackage

// File: rtl/proc_opcodes_pkg.sv
// Shared opcode map for the 8-bit basic processor instruction set.
// Every block that decodes the opcode field takes its encodings from here.
package proc_opcodes_pkg;

  localparam int OPC_W = 3;

  localparam logic [OPC_W-1:0] OPC_NOP   = 3'd0;
  localparam logic [OPC_W-1:0] OPC_LOAD  = 3'd1;
  localparam logic [OPC_W-1:0] OPC_STORE = 3'd2;
  localparam logic [OPC_W-1:0] OPC_ADD   = 3'd3;
  localparam logic [OPC_W-1:0] OPC_SUB   = 3'd4;
  localparam logic [OPC_W-1:0] OPC_BNE   = 3'd5;

endpackage

// File: rtl/proc_wait_timer.sv
// Saturating cycle counter for data-memory ack timeouts; expired is high
// while the count sits at WAIT_MAX-1.
module proc_wait_timer
  import proc_ctrl_pkg::*;
#(
  parameter int WAIT_MAX = WAIT_MAX_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [WAIT_CNT_W-1:0] count_reg;

  assign expired = (count_reg == WAIT_CNT_W'(WAIT_MAX - 1));

  always_ff @(posedge clock) begin
    if (reset || clr) begin
      count_reg <= '0;
    end else if (en && !expired) begin
      count_reg <= count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/proc_sequencer.sv
// Fetch/decode/execute control sequencer with req/ack data-memory handshake
// and sticky timeout fault. Optional PROC_SEQ_SINGLE_STEP_EN adds a step input.
module proc_sequencer
  import proc_ctrl_pkg::*;
  import proc_opcodes_pkg::*;
#(
  parameter int OP_W     = 3,
  parameter int WAIT_MAX = WAIT_MAX_DEFAULT
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [OP_W-1:0] opcode,
  input  logic            z_flag,
  input  logic            dmem_ack,
`ifdef PROC_SEQ_SINGLE_STEP_EN
  input  logic            step,
`endif
  output logic            ir_load,
  output logic            pc_inc,
  output logic            pc_load,
  output logic            acc_load,
  output alu_op_t         alu_op,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic            fault
);

  state_t state_reg;
  state_t state_next;
  logic   timer_clr;
  logic   timer_en;
  logic   timer_expired;
  logic   is_store;

  assign is_store = (opcode == OP_W'(OPC_STORE));

  proc_wait_timer #(
    .WAIT_MAX (WAIT_MAX)
  ) u_wait_timer (
    .clock   (clock),
    .reset   (reset),
    .clr     (timer_clr),
    .en      (timer_en),
    .expired (timer_expired)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  // Outputs are forced low while reset is high, whatever state is held.
  always_comb begin
    state_next = state_reg;
    ir_load    = 1'b0;
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
    acc_load   = 1'b0;
    alu_op     = ALU_PASS;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    fault      = 1'b0;
    timer_clr  = 1'b1;
    timer_en   = 1'b0;
    if (!reset) begin
      case (state_reg)
        FETCH: begin
`ifdef PROC_SEQ_SINGLE_STEP_EN
          if (step) begin
            ir_load    = 1'b1;
            pc_inc     = 1'b1;
            state_next = DECODE;
          end
`else
          ir_load    = 1'b1;
          pc_inc     = 1'b1;
          state_next = DECODE;
`endif
        end
        DECODE: begin
          case (opcode)
            OP_W'(OPC_LOAD), OP_W'(OPC_STORE),
            OP_W'(OPC_ADD), OP_W'(OPC_SUB): state_next = MEM;
            OP_W'(OPC_BNE): begin
              pc_load    = ~z_flag;
              state_next = FETCH;
            end
            default: state_next = FETCH;
          endcase
        end
        MEM: begin
          dmem_req = 1'b1;
          dmem_we  = is_store;
          case (opcode)
            OP_W'(OPC_ADD): alu_op = ALU_ADD;
            OP_W'(OPC_SUB): alu_op = ALU_SUB;
            default:        alu_op = ALU_PASS;
          endcase
          // An ack on the limit cycle still completes the access.
          if (dmem_ack) begin
            acc_load   = ~is_store;
            state_next = FETCH;
          end else if (timer_expired) begin
            state_next = FAULT;
          end else begin
            timer_clr = 1'b0;
            timer_en  = 1'b1;
          end
        end
        FAULT: begin
          fault = 1'b1;
        end
        default: state_next = FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_proc_sequencer.sv
// Directed bench for proc_sequencer: one line per checked cycle, compared
// against hand-computed control vectors.
module tb_proc_sequencer;
  import proc_ctrl_pkg::*;
  import proc_opcodes_pkg::*;

  // Control vector: {ir_load, pc_inc, pc_load, acc_load, alu_op[1:0], dmem_req, dmem_we, fault}
  localparam logic [8:0] V_IDLE   = 9'h000;
  localparam logic [8:0] V_FETCH  = 9'h180;
  localparam logic [8:0] V_BNE_T  = 9'h040;
  localparam logic [8:0] V_ST_ACK = 9'h006;
  localparam logic [8:0] V_ADD_W  = 9'h00C;
  localparam logic [8:0] V_ADD_A  = 9'h02C;
  localparam logic [8:0] V_SUB_A  = 9'h034;
  localparam logic [8:0] V_LD_W   = 9'h004;
  localparam logic [8:0] V_LD_A   = 9'h024;
  localparam logic [8:0] V_FAULT  = 9'h001;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] opcode = '0;
  logic       z_flag = 1'b0;
  logic       dmem_ack = 1'b0;
  logic       step = 1'b1;
  logic       ir_load, pc_inc, pc_load, acc_load, dmem_req, dmem_we, fault;
  alu_op_t    alu_op;
  logic [8:0] ctl;

  int checks_cnt = 0;
  int errors_cnt = 0;

  always #5 clock = ~clock;

  assign ctl = {ir_load, pc_inc, pc_load, acc_load, alu_op, dmem_req, dmem_we, fault};

  proc_sequencer #(
    .OP_W     (3),
    .WAIT_MAX (15)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .opcode   (opcode),
    .z_flag   (z_flag),
    .dmem_ack (dmem_ack),
`ifdef PROC_SEQ_SINGLE_STEP_EN
    .step     (step),
`endif
    .ir_load  (ir_load),
    .pc_inc   (pc_inc),
    .pc_load  (pc_load),
    .acc_load (acc_load),
    .alu_op   (alu_op),
    .dmem_req (dmem_req),
    .dmem_we  (dmem_we),
    .fault    (fault)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got 0x%03h expected 0x%03h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%03h", tag, got);
    end
  endtask

  // Drive inputs just after a rising edge, check mid-cycle, advance one clock.
  task automatic cyc(input string tag, input logic [2:0] op, input logic z,
                     input logic ack, input logic [8:0] exp);
    opcode   = op;
    z_flag   = z;
    dmem_ack = ack;
    #1;
    check(tag, {23'd0, ctl}, {23'd0, exp});
    @(posedge clock);
    #1;
  endtask

  initial begin
    // Reset held two cycles, outputs low throughout
    @(posedge clock); #1;
    check("rst_c1", {23'd0, ctl}, {23'd0, V_IDLE});
    @(posedge clock); #1;
    check("rst_c2", {23'd0, ctl}, {23'd0, V_IDLE});
    reset = 1'b0;

    // First fetch, then NOP with a stray ack (ignored outside MEM)
    cyc("fetch_first", OPC_NOP, 1'b0, 1'b0, V_FETCH);
    cyc("nop_decode", OPC_NOP, 1'b0, 1'b1, V_IDLE);

    // STORE with immediate ack: 3 cycles
    cyc("st_fetch", OPC_STORE, 1'b0, 1'b0, V_FETCH);
    cyc("st_decode", OPC_STORE, 1'b0, 1'b0, V_IDLE);
    cyc("st_mem_ack", OPC_STORE, 1'b0, 1'b1, V_ST_ACK);

    // ADD with ack delayed three cycles
    cyc("add_fetch", OPC_ADD, 1'b0, 1'b0, V_FETCH);
    cyc("add_decode", OPC_ADD, 1'b0, 1'b0, V_IDLE);
    for (int i = 0; i < 3; i++) cyc("add_mem_wait", OPC_ADD, 1'b0, 1'b0, V_ADD_W);
    cyc("add_mem_ack", OPC_ADD, 1'b0, 1'b1, V_ADD_A);

    // SUB with immediate ack
    cyc("sub_fetch", OPC_SUB, 1'b0, 1'b0, V_FETCH);
    cyc("sub_decode", OPC_SUB, 1'b0, 1'b0, V_IDLE);
    cyc("sub_mem_ack", OPC_SUB, 1'b0, 1'b1, V_SUB_A);

    // BNE taken, then not taken: 2 cycles each
    cyc("bne0_fetch", OPC_BNE, 1'b0, 1'b0, V_FETCH);
    cyc("bne0_decode", OPC_BNE, 1'b0, 1'b0, V_BNE_T);
    cyc("bne1_fetch", OPC_BNE, 1'b1, 1'b0, V_FETCH);
    cyc("bne1_decode", OPC_BNE, 1'b1, 1'b0, V_IDLE);

    // LOAD with ack on the 15th MEM cycle: no fault
    cyc("ld15_fetch", OPC_LOAD, 1'b0, 1'b0, V_FETCH);
    cyc("ld15_decode", OPC_LOAD, 1'b0, 1'b0, V_IDLE);
    for (int i = 0; i < 14; i++) cyc("ld15_mem_wait", OPC_LOAD, 1'b0, 1'b0, V_LD_W);
    cyc("ld15_mem_ack", OPC_LOAD, 1'b0, 1'b1, V_LD_A);

    // LOAD with no ack: FAULT after 15 MEM cycles, sticky for 20 more
    cyc("ldto_fetch", OPC_LOAD, 1'b0, 1'b0, V_FETCH);
    cyc("ldto_decode", OPC_LOAD, 1'b0, 1'b0, V_IDLE);
    for (int i = 0; i < 15; i++) cyc("ldto_mem_wait", OPC_LOAD, 1'b0, 1'b0, V_LD_W);
    for (int i = 0; i < 20; i++) cyc("fault_sticky", OPC_LOAD, 1'b0, 1'(i % 2), V_FAULT);
    reset = 1'b1;
    cyc("fault_rst", OPC_LOAD, 1'b0, 1'b0, V_IDLE);
    reset = 1'b0;

    // Reset during the 2nd MEM cycle of LOAD, counter restarts afterwards
    cyc("ldrst_fetch", OPC_LOAD, 1'b0, 1'b0, V_FETCH);
    cyc("ldrst_decode", OPC_LOAD, 1'b0, 1'b0, V_IDLE);
    cyc("ldrst_mem1", OPC_LOAD, 1'b0, 1'b0, V_LD_W);
    reset = 1'b1;
    cyc("ldrst_mem2_rst", OPC_LOAD, 1'b0, 1'b0, V_IDLE);
    reset = 1'b0;
    cyc("ldrst_refetch", OPC_LOAD, 1'b0, 1'b0, V_FETCH);
    cyc("ldrst_redecode", OPC_LOAD, 1'b0, 1'b0, V_IDLE);
    for (int i = 0; i < 14; i++) cyc("ldrst_mem_wait", OPC_LOAD, 1'b0, 1'b0, V_LD_W);
    cyc("ldrst_mem_ack", OPC_LOAD, 1'b0, 1'b1, V_LD_A);
    cyc("final_fetch", OPC_NOP, 1'b0, 1'b0, V_FETCH);

    $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
